// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch state encoding, instruction width and PC constants.
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, single-entry output buffer
// towards decode, redirect port with in-flight kill of wrong-path responses.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_o,
    output logic [31:0]        imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
    output logic               addr_err_o
);

    fetch_state_e       state_q;
    logic [31:0]        pc_q;
    logic [31:0]        pc_out_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               kill_q;
    logic               handshake;
    logic [31:0]        redirect_target;

    assign redirect_target = {redirect_pc_i[31:2], 2'b00};
    assign handshake       = valid_q & instr_ready_i;

    // A redirect in the same cycle always wins over issuing a request.
    assign imem_req_o  = ~redirect_i & ((state_q == FETCH) | ((state_q == HOLD) & handshake));
    assign imem_addr_o = pc_q;
    assign addr_err_o  = rst_n & redirect_i & (redirect_pc_i[1:0] != 2'b00);

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;
    assign pc_plus4_o    = pc_out_q + PC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= '0;
        end else begin
            if (redirect_i) begin
                pc_q <= redirect_target;
            end
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (!redirect_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        // Wrong-path data (killed earlier or redirected now) is dropped.
                        if (redirect_i || kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= FETCH;
                        end else begin
                            instr_q  <= imem_rdata_i;
                            pc_out_q <= pc_q;
                            pc_q     <= pc_q + PC_INC;
                            valid_q  <= 1'b1;
                            state_q  <= HOLD;
                        end
                    end else if (redirect_i) begin
                        kill_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_i || instr_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= redirect_i ? FETCH : WAIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with programmable latency and a
// scoreboard of expected request addresses and decode transfers.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        addr_err_o;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int mem_lat = 1;

    mreq_t       mem_q[$];
    logic [31:0] exp_req[$];
    xfer_t       exp_xfer[$];

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .addr_err_o    (addr_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic xfer_t mk_xfer(input logic [31:0] a);
        xfer_t x;
        x.instr = mem_word(a);
        x.pc    = a;
        x.pc4   = a + 32'd4;
        return x;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory response side: drives rvalid/rdata just after the edge of the due cycle.
    task automatic mem_rsp_proc();
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(mem_q[0].addr);
                mem_q.delete(0);
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'hDEAD_BEEF;
            end
        end
    endtask

    // Mid-cycle observer: accepts requests into the memory and scores requests/transfers.
    task automatic mon_proc();
        mreq_t       m;
        logic [31:0] a;
        xfer_t       x;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (imem_req_o === 1'b1) begin
                    m.addr = imem_addr_o;
                    m.due  = cyc + mem_lat;
                    mem_q.push_back(m);
                    tests_run++;
                    if (exp_req.size() == 0) begin
                        tests_failed++;
                        $display("FAIL sb_req: request to %h, required no request", imem_addr_o);
                    end else begin
                        a = exp_req.pop_front();
                        if (imem_addr_o !== a) begin
                            tests_failed++;
                            $display("FAIL sb_req: addr %h, required %h", imem_addr_o, a);
                        end
                    end
                end
                if (instr_valid_o === 1'b1 && instr_ready_i === 1'b1) begin
                    tests_run++;
                    if (exp_xfer.size() == 0) begin
                        tests_failed++;
                        $display("FAIL sb_xfer: transfer pc=%h, required no transfer", pc_o);
                    end else begin
                        x = exp_xfer.pop_front();
                        if ({instr_o, pc_o, pc_plus4_o} !== {x.instr, x.pc, x.pc4}) begin
                            tests_failed++;
                            $display("FAIL sb_xfer: instr=%h pc=%h pc4=%h, required instr=%h pc=%h pc4=%h",
                                     instr_o, pc_o, pc_plus4_o, x.instr, x.pc, x.pc4);
                        end
                    end
                end
            end
        end
    endtask

    task automatic reset_and_release(input int lat, input logic rdy);
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = rdy;
        mem_lat       = lat;
        mem_q.delete();
        exp_req.delete();
        exp_xfer.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL rst_req: %b, required 0", imem_req_o); end
        tests_run++; if (instr_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: %b, required 0", instr_valid_o); end
        tests_run++; if (addr_err_o !== 1'b0) begin tests_failed++; $display("FAIL rst_addr_err: %b, required 0", addr_err_o); end
        tests_run++; if (instr_o !== 32'h0) begin tests_failed++; $display("FAIL rst_instr: %h, required 0", instr_o); end
        tests_run++; if (pc_o !== 32'h0) begin tests_failed++; $display("FAIL rst_pc: %h, required 0", pc_o); end
        tests_run++; if (pc_plus4_o !== 32'h4) begin tests_failed++; $display("FAIL rst_pc4: %h, required 4", pc_plus4_o); end
        tests_run++; if (imem_addr_o !== RST_PC) begin tests_failed++; $display("FAIL rst_addr: %h, required %h", imem_addr_o, RST_PC); end
    endtask

    task automatic test_stream();
        reset_and_release(1, 1'b1);
        for (int i = 0; i < 4; i++) exp_req.push_back(RST_PC + 32'(4 * i));
        for (int i = 0; i < 3; i++) exp_xfer.push_back(mk_xfer(RST_PC + 32'(4 * i)));
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            @(negedge clk);
            tests_run++;
            if (imem_req_o !== 1'(k % 2)) begin
                tests_failed++;
                $display("FAIL stream_req_%0d: %b, required %b", k, imem_req_o, 1'(k % 2));
            end
            if (k == 3) begin
                tests_run++;
                if (pc_plus4_o !== 32'hBFC0_0004) begin
                    tests_failed++;
                    $display("FAIL stream_pc4_first: %h, required bfc00004", pc_plus4_o);
                end
            end
        end
        next_cycle();
        instr_ready_i = 1'b0;
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (instr_valid_o === 1'b1) found = 1'b1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL stall_wait_valid: timeout, required valid within 10 cycles"); end
        exp_xfer.push_back(mk_xfer(RST_PC + 32'hC));
        exp_req.push_back(RST_PC + 32'h10);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            tests_run++; if (instr_o !== mem_word(RST_PC + 32'hC)) begin tests_failed++; $display("FAIL stall_instr_%0d: %h, required %h", k, instr_o, mem_word(RST_PC + 32'hC)); end
            tests_run++; if (pc_o !== RST_PC + 32'hC) begin tests_failed++; $display("FAIL stall_pc_%0d: %h, required %h", k, pc_o, RST_PC + 32'hC); end
            tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL stall_req_%0d: %b, required 0", k, imem_req_o); end
            tests_run++; if (instr_valid_o !== 1'b1) begin tests_failed++; $display("FAIL stall_valid_%0d: %b, required 1", k, instr_valid_o); end
        end
        next_cycle();
        instr_ready_i = 1'b1;
        #2;
        tests_run++; if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL stall_release_req: %b, required 1", imem_req_o); end
        tests_run++; if (imem_addr_o !== RST_PC + 32'h10) begin tests_failed++; $display("FAIL stall_release_addr: %h, required %h", imem_addr_o, RST_PC + 32'h10); end
        next_cycle();
        instr_ready_i = 1'b0;
        repeat (4) next_cycle();
        tests_run++;
        if (exp_req.size() != 0 || exp_xfer.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_stall: %0d req / %0d xfer outstanding, required 0", exp_req.size(), exp_xfer.size());
        end
    endtask

    task automatic test_redirect_wait();
        reset_and_release(3, 1'b1);
        exp_req.push_back(RST_PC);
        exp_req.push_back(32'h0040_0020);
        exp_req.push_back(32'h0040_0024);
        exp_xfer.push_back(mk_xfer(32'h0040_0020));
        next_cycle();
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0020;
        for (int k = 2; k <= 8; k++) begin
            if (k > 2) begin
                next_cycle();
                redirect_i = 1'b0;
            end
            @(negedge clk);
            if (k == 2) begin
                tests_run++; if (addr_err_o !== 1'b0) begin tests_failed++; $display("FAIL rw_addr_err: %b, required 0", addr_err_o); end
            end
            tests_run++;
            if (instr_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rw_no_valid_%0d: %b, required 0", k, instr_valid_o); end
            if (k >= 3 && k <= 5) begin
                tests_run++;
                if (imem_req_o !== (k == 5)) begin tests_failed++; $display("FAIL rw_req_%0d: %b, required %b", k, imem_req_o, (k == 5)); end
            end
        end
        next_cycle();
        @(negedge clk);
        tests_run++; if (instr_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rw_valid_target: %b, required 1", instr_valid_o); end
        next_cycle();
        instr_ready_i = 1'b0;
        repeat (4) next_cycle();
        tests_run++;
        if (exp_req.size() != 0 || exp_xfer.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_redirect_wait: %0d req / %0d xfer outstanding, required 0", exp_req.size(), exp_xfer.size());
        end
    endtask

    task automatic test_redirect_hold();
        reset_and_release(1, 1'b0);
        exp_req.push_back(RST_PC);
        exp_req.push_back(32'h0040_0100);
        exp_req.push_back(32'h0040_0104);
        exp_xfer.push_back(mk_xfer(RST_PC));
        exp_xfer.push_back(mk_xfer(32'h0040_0100));
        repeat (3) next_cycle();
        @(negedge clk);
        tests_run++; if (instr_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rh_hold_valid: %b, required 1", instr_valid_o); end
        next_cycle();
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0100;
        @(negedge clk);
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL rh_no_req: %b, required 0", imem_req_o); end
        next_cycle();
        redirect_i = 1'b0;
        @(negedge clk);
        tests_run++; if (instr_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rh_valid_clear: %b, required 0", instr_valid_o); end
        tests_run++; if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL rh_req_target: %b, required 1", imem_req_o); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests_run++; if (instr_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rh_valid_target: %b, required 1", instr_valid_o); end
        next_cycle();
        instr_ready_i = 1'b0;
        repeat (4) next_cycle();
        tests_run++;
        if (exp_req.size() != 0 || exp_xfer.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_redirect_hold: %0d req / %0d xfer outstanding, required 0", exp_req.size(), exp_xfer.size());
        end
    endtask

    task automatic test_addr_err();
        reset_and_release(1, 1'b1);
        exp_req.push_back(32'h0040_0020);
        exp_req.push_back(32'h0040_0024);
        exp_xfer.push_back(mk_xfer(32'h0040_0020));
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0022;
        @(negedge clk);
        tests_run++; if (addr_err_o !== 1'b1) begin tests_failed++; $display("FAIL ae_pulse: %b, required 1", addr_err_o); end
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL ae_req_suppressed: %b, required 0", imem_req_o); end
        next_cycle();
        redirect_i = 1'b0;
        @(negedge clk);
        tests_run++; if (addr_err_o !== 1'b0) begin tests_failed++; $display("FAIL ae_pulse_end: %b, required 0", addr_err_o); end
        tests_run++; if (imem_addr_o !== 32'h0040_0020) begin tests_failed++; $display("FAIL ae_aligned_addr: %h, required 00400020", imem_addr_o); end
        next_cycle();
        next_cycle();
        next_cycle();
        instr_ready_i = 1'b0;
        repeat (4) next_cycle();
        tests_run++;
        if (exp_req.size() != 0 || exp_xfer.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_addr_err: %0d req / %0d xfer outstanding, required 0", exp_req.size(), exp_xfer.size());
        end
    endtask

    task automatic test_wrap();
        reset_and_release(1, 1'b1);
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0000_0000);
        exp_xfer.push_back(mk_xfer(32'hFFFF_FFFC));
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        next_cycle();
        redirect_i = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests_run++; if (pc_plus4_o !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc4: %h, required 0", pc_plus4_o); end
        tests_run++; if (imem_req_o !== 1'b1) begin tests_failed++; $display("FAIL wrap_req: %b, required 1", imem_req_o); end
        tests_run++; if (imem_addr_o !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr: %h, required 0", imem_addr_o); end
        next_cycle();
        instr_ready_i = 1'b0;
        repeat (4) next_cycle();
        tests_run++;
        if (exp_req.size() != 0 || exp_xfer.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_wrap: %0d req / %0d xfer outstanding, required 0", exp_req.size(), exp_xfer.size());
        end
    endtask

    task automatic test_async_reset();
        reset_and_release(3, 1'b1);
        exp_req.push_back(RST_PC);
        exp_req.push_back(RST_PC + 32'h4);
        exp_xfer.push_back(mk_xfer(RST_PC));
        repeat (6) next_cycle();
        @(negedge clk);
        tests_run++; if (pc_o !== RST_PC) begin tests_failed++; $display("FAIL ar_pre_pc: %h, required %h", pc_o, RST_PC); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (imem_req_o !== 1'b0) begin tests_failed++; $display("FAIL ar_req: %b, required 0", imem_req_o); end
        tests_run++; if (instr_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ar_valid: %b, required 0", instr_valid_o); end
        tests_run++; if (addr_err_o !== 1'b0) begin tests_failed++; $display("FAIL ar_addr_err: %b, required 0", addr_err_o); end
        tests_run++; if (instr_o !== 32'h0) begin tests_failed++; $display("FAIL ar_instr: %h, required 0", instr_o); end
        tests_run++; if (pc_o !== 32'h0) begin tests_failed++; $display("FAIL ar_pc: %h, required 0", pc_o); end
        tests_run++; if (pc_plus4_o !== 32'h4) begin tests_failed++; $display("FAIL ar_pc4: %h, required 4", pc_plus4_o); end
        tests_run++; if (imem_addr_o !== RST_PC) begin tests_failed++; $display("FAIL ar_addr: %h, required %h", imem_addr_o, RST_PC); end
        tests_run++;
        if (exp_req.size() != 0 || exp_xfer.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_pre_reset: %0d req / %0d xfer outstanding, required 0", exp_req.size(), exp_xfer.size());
        end
        // The stale response to RST_PC+4 is still queued and lands in FETCH after release.
        exp_req.push_back(RST_PC);
        exp_req.push_back(RST_PC + 32'h4);
        exp_xfer.push_back(mk_xfer(RST_PC));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) next_cycle();
        @(negedge clk);
        tests_run++; if (instr_o !== mem_word(RST_PC)) begin tests_failed++; $display("FAIL ar_post_instr: %h, required %h", instr_o, mem_word(RST_PC)); end
        next_cycle();
        instr_ready_i = 1'b0;
        repeat (4) next_cycle();
        tests_run++;
        if (exp_req.size() != 0 || exp_xfer.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_async_reset: %0d req / %0d xfer outstanding, required 0", exp_req.size(), exp_xfer.size());
        end
    endtask

    initial begin
        fork
            mem_rsp_proc();
            mon_proc();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not complete, required completion before 200000");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_addr_err();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS core, directly upstream of instruction decode. Holds the program counter, issues word reads to instruction memory with at most one request outstanding, and presents each returned instruction with its PC to decode through a valid/ready handshake. Branch and jump resolution redirects the PC through a single redirect port. Wrong-path data is killed in flight.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_o  out  1  read request; memory accepts it in the same cycle
- imem_addr_o  out  32  word-aligned read address; equals pc_q whenever imem_req_o=1
- imem_rvalid_i  in  1  read data valid; responses arrive in order, latency ≥1 cycle
- imem_rdata_i  in  32  instruction word
- redirect_i  in  1  one-cycle pulse that loads a new PC
- redirect_pc_i  in  32  redirect target
- instr_valid_o  out  1  instr_o, pc_o and pc_plus4_o are valid
- instr_ready_i  in  1  decode accepts the instruction
- instr_o  out  32  instruction word, fed to decode
- pc_o  out  32  address of instr_o
- pc_plus4_o  out  32  pc_o + 4
- addr_err_o  out  1  one-cycle pulse: redirect_pc_i[1:0] != 0

## Operation
- State machine states:
  - IDLE: reset state.
  - FETCH: issue the request.
  - WAIT: one read is outstanding.
  - HOLD: the output buffer is full.
- IDLE: imem_req_o=0. Moves to FETCH on the next clock.
- FETCH: imem_req_o=1 and imem_addr_o=pc_q, then move to WAIT.
- WAIT: on imem_rvalid_i the fetch is captured as follows, then move to HOLD:
  - instr_q ← rdata
  - pc_out_q ← pc_q
  - pc_q ← pc_q+4
  - instr_valid_o ← 1
- HOLD: instr_valid_o=1 and all output fields are stable.
  - Handshake completes when instr_valid_o & instr_ready_i.
  - On handshake with no redirect: a request is issued in the same cycle, imem_req_o=1 and addr=pc_q, then move to WAIT.
  - At the clock edge that moves HOLD to WAIT, instr_valid_o clears.
- Redirect has priority in every state. pc_q ← {redirect_pc_i[31:2], 2'b00}.
  - If redirect_pc_i[1:0] != 0, addr_err_o pulses in the same cycle.
  - FETCH: the request is suppressed in that cycle (imem_req_o=0). Stay in FETCH.
  - WAIT without rvalid in the same cycle: set kill_q. The next rvalid is discarded, kill_q clears and the FSM moves to FETCH.
  - WAIT with rvalid in the same cycle: the data is discarded and the FSM moves to FETCH. kill_q is not set.
  - HOLD: the buffered instruction is dropped and instr_valid_o clears next cycle. Any handshake in that cycle still counts as a transfer. No request is issued. Move to FETCH.
  - IDLE: pc_q is loaded and the FSM still moves to FETCH.
- PC arithmetic is 32-bit modulo 2^32. pc_q=32'hFFFF_FFFC wraps to 0. pc_plus4_o uses the same wrap.
- imem_rvalid_i is ignored in IDLE, FETCH and HOLD. This is a protocol violation and never corrupts state.

## Timing
- Reset values (asynchronous):
  - state=IDLE
  - pc_q=RESET_PC
  - kill_q=0
  - instr_valid_o=0, imem_req_o=0, addr_err_o=0
  - instr_o=0, pc_o=0, pc_plus4_o=4
- First request goes out in the 2nd cycle after rst_n rises.
- With a 1-cycle memory:
  - request at cycle n, rvalid at n+1, instr_valid_o at n+2
  - with instr_ready_i held high: 2 cycles per instruction
- Stall: instr_ready_i=0 holds HOLD indefinitely with outputs frozen.
- Redirect-to-request latency is 1 cycle. Redirect at cycle n gives the next request at n+1 with addr = target, except when the FSM is waiting on a killed response.
- Reset mid-operation:
  - all state clears immediately
  - an outstanding response is dropped because it arrives in IDLE or FETCH (ignored), or is the killed response

## Structure
- Shared package mips_pkg:
  - fetch state enum (IDLE, FETCH, WAIT, HOLD)
  - INSTR_W=32
  - PC_INC=32'd4
  - default reset vector constant
- Single module with no sub-module. The output buffer is three registers.

## Test plan
- Reset release, RESET_PC=32'hBFC0_0000, 1-cycle memory, ready=1 → requests to BFC00000, BFC00004, BFC00008 every 2 cycles; pc_plus4_o=BFC00004 with the first instruction.
- ready=0 for 5 cycles in HOLD → instr_o/pc_o stable, imem_req_o=0. Ready rises → request to next PC in the same cycle.
- Redirect to 0x00400020 during WAIT, 3-cycle memory → stale response discarded, next request to 0x00400020, no instr_valid_o for the stale word.
- Redirect in HOLD coinciding with the handshake → the instruction is transferred once and the next address = redirect target.
- redirect_pc_i=0x00400022 → addr_err_o pulses 1 cycle, fetch from 0x00400020.
- PC at 0xFFFFFFFC → pc_plus4_o=0, next request to 0x00000000. Async reset asserted in WAIT → all outputs reach reset values without a clock edge.
